// File: rtl/button_debouncer.sv
// Debounces a raw asynchronous button level into a clean synchronous level
// and emits one-cycle rise/fall strobes when that level changes.
module button_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic q_rise,
  output logic q_fall,
  output logic busy
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               SINGLE   = (STABLE_CYCLES == 1);

  logic             sync_p0;
  logic             sync_p1;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      state   <= STABLE_LO;
      cnt     <= '0;
      q       <= 1'b0;
      q_rise  <= 1'b0;
      q_fall  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      // stage p0/p1: two-flop synchronizer; only sync_p1 reaches the FSM
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      // FSM stage: strobes default low, outputs follow the next state
      q_rise  <= 1'b0;
      q_fall  <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (!sync_p1) begin
            cnt <= '0;
          end else if (SINGLE) begin
            state  <= STABLE_HI;
            cnt    <= '0;
            q      <= 1'b1;
            q_rise <= 1'b1;
            busy   <= 1'b0;
          end else begin
            state <= PEND_HI;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end
        end
        PEND_HI: begin
          if (!sync_p1) begin
            state <= STABLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state  <= STABLE_HI;
            cnt    <= '0;
            q      <= 1'b1;
            q_rise <= 1'b1;
            busy   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (sync_p1) begin
            cnt <= '0;
          end else if (SINGLE) begin
            state  <= STABLE_LO;
            cnt    <= '0;
            q      <= 1'b0;
            q_fall <= 1'b1;
            busy   <= 1'b0;
          end else begin
            state <= PEND_LO;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end
        end
        PEND_LO: begin
          // a bounce back to high abandons the pending release
          if (sync_p1) begin
            state <= STABLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state  <= STABLE_LO;
            cnt    <= '0;
            q      <= 1'b0;
            q_fall <= 1'b1;
            busy   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
          q     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bouncing, checked
// against a run-length model of the debounce rule for N=4 and N=1 builds.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic q4, r4, f4, b4;
  logic q1, r1, f1, b1;

  int checks = 0;
  int errors = 0;

  // model state: last two sampled din values stand in for the sync delay
  bit h1, h2;
  int n_of [2] = '{4, 1};
  bit m_q [2];
  int m_run [2];
  bit m_rise [2];
  bit m_fall [2];

  always #5 clk = ~clk;

  button_debouncer #(.STABLE_CYCLES(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .din(din),
    .q(q4), .q_rise(r4), .q_fall(f4), .busy(b4)
  );

  button_debouncer #(.STABLE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .din(din),
    .q(q1), .q_rise(r1), .q_fall(f1), .busy(b1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // the debounce rule: q flips after N consecutive level samples that differ from it
  task automatic model_edge(input bit d, input bit r);
    bit sync;
    sync = h2;
    for (int k = 0; k < 2; k++) begin
      m_rise[k] = 1'b0;
      m_fall[k] = 1'b0;
      if (r) begin
        m_q[k] = 1'b0;
        m_run[k] = 0;
      end else if (sync != m_q[k]) begin
        m_run[k]++;
        if (m_run[k] == n_of[k]) begin
          m_q[k] = ~m_q[k];
          m_run[k] = 0;
          m_rise[k] = m_q[k];
          m_fall[k] = ~m_q[k];
        end
      end else begin
        m_run[k] = 0;
      end
    end
    if (r) begin
      h1 = 1'b0;
      h2 = 1'b0;
    end else begin
      h2 = h1;
      h1 = d;
    end
  endtask

  task automatic step(input bit d, input bit r);
    @(negedge clk);
    din = d;
    rst = r;
    @(posedge clk);
    model_edge(d, r);
    #1;
    chk("q_n4", q4, m_q[0]);
    chk("rise_n4", r4, m_rise[0]);
    chk("fall_n4", f4, m_fall[0]);
    chk("busy_n4", b4, m_run[0] != 0);
    chk("q_n1", q1, m_q[1]);
    chk("rise_n1", r1, m_rise[1]);
    chk("fall_n1", f1, m_fall[1]);
    chk("busy_n1", b1, m_run[1] != 0);
  endtask

  initial begin
    int rise_at4, rise_at1, rises, busy1_seen;
    bit bounce [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // reset
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("reset_q", q4, 1'b0);
    chk("reset_busy", b4, 1'b0);

    // clean press: din high before edge 0
    rise_at4 = -1;
    rise_at1 = -1;
    busy1_seen = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0);
      if (r4 === 1'b1 && rise_at4 < 0) rise_at4 = i;
      if (r1 === 1'b1 && rise_at1 < 0) rise_at1 = i;
      if (b1 === 1'b1) busy1_seen++;
      if (i >= 2 && i <= 4) chk("press_busy", b4, 1'b1);
      if (i <= 4) chk("press_q_low", q4, 1'b0);
    end
    chk_int("press_rise_edge_n4", rise_at4, 5);
    chk_int("press_rise_edge_n1", rise_at1, 2);
    chk_int("n1_busy_never", busy1_seen, 0);

    // release after stable high
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
    chk("release_q", q4, 1'b0);

    // short glitch
    rises = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      if (r4 === 1'b1) rises++;
    end
    chk_int("glitch_no_rise", rises, 0);
    chk("glitch_q", q4, 1'b0);

    // bouncy press
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      step(bounce[i], 1'b0);
      if (r4 === 1'b1) rises++;
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      if (r4 === 1'b1) rises++;
    end
    chk_int("bounce_one_rise", rises, 1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0);

    // reset while pending (cnt=2 after the fourth edge)
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    chk("pend_busy", b4, 1'b1);
    step(1'b1, 1'b1);
    chk("midrst_q", q4, 1'b0);
    chk("midrst_busy", b4, 1'b0);
    rise_at4 = -1;
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0);
      if (r4 === 1'b1 && rise_at4 < 0) rise_at4 = i;
    end
    chk_int("midrst_rise_edge", rise_at4, 6);

    // random bouncing with occasional reset
    for (int i = 0; i < 3000; i++) begin
      bit d;
      if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 1) == 1;
      else d = din;
      step(d, $urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
